// File: rtl/program_loader_pkg.sv
// program_loader_pkg: loader FSM state encodings shared by the program loader slice.
package program_loader_pkg;
  localparam int LOADER_STATE_WIDTH = 2;
  typedef enum logic [LOADER_STATE_WIDTH-1:0] {
    LOADER_IDLE  = 2'd0,
    LOADER_LOAD  = 2'd1,
    LOADER_DRAIN = 2'd2,
    LOADER_DONE  = 2'd3
  } loader_state_e;
endpackage

// File: rtl/program_loader_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with full/empty flags and occupancy count.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
  assign rdata = mem[rd_ptr];
  assign full  = count == (PTR_WIDTH+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_WIDTH'(push);
      rd_ptr <= rd_ptr + PTR_WIDTH'(pop);
      count  <= count + (PTR_WIDTH+1)'(push) - (PTR_WIDTH+1)'(pop);
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: buffers UART debug word writes and steers them to imem/dmem while holding the CPU.
// Optional PROGRAM_LOADER_REGION_GUARD_EN rejects out-of-range data-region addresses.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ISA_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 15,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_PTR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [ISA_WIDTH-1:0]  uart_data,
  input  logic                  uart_write_enable,
  input  logic                  uart_complete,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  output logic [ISA_WIDTH-1:0]  mem_data,
  output logic                  imem_we,
  output logic                  dmem_we,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic [ADDR_WIDTH-1:0] word_count,
  output logic [ISA_WIDTH-1:0]  checksum,
  output logic                  overflow_err
);
  localparam int EW = ADDR_WIDTH + ISA_WIDTH;
  loader_state_e state, state_next;
  logic [EW-1:0] head;
  logic full, empty, push, pop, drop, rej, start, drained;
  logic [FIFO_PTR_WIDTH:0] count;
  logic [ADDR_WIDTH-2:0] last_addr;
  logic [ISA_WIDTH-1:0] last_data;
  logic [ADDR_WIDTH-1:0] wc_base;
`ifdef PROGRAM_LOADER_REGION_GUARD_EN
  assign drop = uart_addr[ADDR_WIDTH-1] & uart_addr[ADDR_WIDTH-2];
`else
  assign drop = 1'b0;
`endif
  assign pop     = !empty & mem_ready;
  assign push    = uart_write_enable & !drop & (!full | pop);
  assign rej     = uart_write_enable & (drop | (full & !pop));
  assign start   = state == LOADER_IDLE & (uart_write_enable | uart_complete);
  assign drained = !push & (empty | (pop & count == (FIFO_PTR_WIDTH+1)'(1)));
  assign wc_base = start ? '0 : word_count;
  assign imem_we  = !empty & !head[EW-1];
  assign dmem_we  = !empty & head[EW-1];
  assign mem_addr = empty ? last_addr : head[EW-2:ISA_WIDTH];
  assign mem_data = empty ? last_data : head[ISA_WIDTH-1:0];
  sync_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH), .PTR_WIDTH(FIFO_PTR_WIDTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop),
    .wdata({uart_addr, uart_data}), .rdata(head),
    .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_next = state;
    case (state)
      LOADER_IDLE:  state_next = uart_write_enable ? (uart_complete ? LOADER_DRAIN : LOADER_LOAD)
                               : uart_complete ? LOADER_DONE : LOADER_IDLE;
      LOADER_LOAD:  state_next = uart_complete ? LOADER_DRAIN : LOADER_LOAD;
      LOADER_DRAIN: state_next = drained ? LOADER_DONE : LOADER_DRAIN;
      LOADER_DONE:  state_next = uart_write_enable ? (uart_complete ? LOADER_DRAIN : LOADER_LOAD)
                               : LOADER_IDLE;
      default:      state_next = LOADER_IDLE;
    endcase
  end
  // An empty program pulses load_done without ever stalling the CPU.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LOADER_IDLE;
      cpu_hold     <= 1'b0;
      load_done    <= 1'b0;
      word_count   <= '0;
      checksum     <= '0;
      overflow_err <= 1'b0;
      last_addr    <= '0;
      last_data    <= '0;
    end else begin
      state        <= state_next;
      cpu_hold     <= state_next != LOADER_IDLE && !(state == LOADER_IDLE && state_next == LOADER_DONE);
      load_done    <= state_next == LOADER_DONE;
      word_count   <= push && !(&wc_base) ? wc_base + ADDR_WIDTH'(1) : wc_base;
      checksum     <= (start ? '0 : checksum) + (push ? uart_data : '0);
      overflow_err <= (!start & overflow_err) | rej;
      last_addr    <= mem_addr;
      last_data    <= mem_data;
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: table-driven vectors plus directed multi-cycle sequences for program_loader.
module tb_program_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic [14:0] uart_addr;
  logic [31:0] uart_data;
  logic uart_write_enable, uart_complete, mem_ready;
  logic [13:0] mem_addr;
  logic [31:0] mem_data;
  logic imem_we, dmem_we, cpu_hold, load_done, overflow_err;
  logic [14:0] word_count;
  logic [31:0] checksum;
  int pass = 0, total = 0;

  typedef struct {
    logic we, cpl, rdy;
    logic [14:0] addr;
    logic [31:0] data;
    logic imem, dmem, hold, done;
    logic [13:0] maddr;
    logic [31:0] mdata;
    logic [14:0] wc;
    logic [31:0] cks;
    logic ovf;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  program_loader dut (
    .clk(clk), .rst_n(rst_n), .uart_addr(uart_addr), .uart_data(uart_data),
    .uart_write_enable(uart_write_enable), .uart_complete(uart_complete), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .imem_we(imem_we), .dmem_we(dmem_we),
    .cpu_hold(cpu_hold), .load_done(load_done), .word_count(word_count),
    .checksum(checksum), .overflow_err(overflow_err)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic seen;
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 15'h0000, 32'h00000013, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0, 32'h00000013, 15'd1, 32'h00000013, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 15'h0001, 32'h00100093, 1'b1, 1'b0, 1'b1, 1'b0, 14'h1, 32'h00100093, 15'd2, 32'h001000A6, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 15'h0002, 32'h00208133, 1'b1, 1'b0, 1'b1, 1'b0, 14'h2, 32'h00208133, 15'd3, 32'h003081D9, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 14'h2, 32'h00208133, 15'd3, 32'h003081D9, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 14'h2, 32'h00208133, 15'd3, 32'h003081D9, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h2, 32'h00208133, 15'd3, 32'h003081D9, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 15'h4005, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 15'h0000, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 15'h0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 14'h5, 32'hDEADBEEF, 15'd1, 32'hDEADBEEF, 1'b0};

    rst_n = 1'b0;
    uart_addr = '0;
    uart_data = '0;
    uart_write_enable = 1'b0;
    uart_complete = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("reset_ctl", 64'({imem_we, dmem_we, cpu_hold, load_done, overflow_err}), 64'(5'b0));
    chk("reset_mem", 64'({mem_addr, mem_data}), 64'(0));
    chk("reset_cnt", 64'({word_count, checksum}), 64'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      uart_write_enable = vecs[i].we;
      uart_complete = vecs[i].cpl;
      mem_ready = vecs[i].rdy;
      uart_addr = vecs[i].addr;
      uart_data = vecs[i].data;
      tick();
      chk($sformatf("vec%0d_ctl", i), 64'({imem_we, dmem_we, cpu_hold, load_done, overflow_err}),
          64'({vecs[i].imem, vecs[i].dmem, vecs[i].hold, vecs[i].done, vecs[i].ovf}));
      chk($sformatf("vec%0d_mem", i), 64'({mem_addr, mem_data}), 64'({vecs[i].maddr, vecs[i].mdata}));
      chk($sformatf("vec%0d_cnt", i), 64'({word_count, checksum}), 64'({vecs[i].wc, vecs[i].cks}));
    end
    uart_write_enable = 1'b0;
    uart_complete = 1'b0;

    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      uart_write_enable = 1'b1;
      uart_addr = 15'h10 + 15'(i);
      uart_data = 32'd100 + 32'(i);
      tick();
    end
    uart_write_enable = 1'b0;
    chk("ovf_flag", 64'({overflow_err, cpu_hold}), 64'(2'b11));
    chk("ovf_cnt", 64'({word_count, checksum}), 64'({15'd4, 32'd406}));
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'b1;
      chk($sformatf("ovf_drain%0d", k), 64'({imem_we, dmem_we, mem_addr, mem_data}),
          64'({1'b1, 1'b0, 14'h10 + 14'(k), 32'd100 + 32'(k)}));
      tick();
    end
    chk("ovf_drained", 64'({imem_we, dmem_we}), 64'(0));
    uart_complete = 1'b1;
    tick();
    uart_complete = 1'b0;
    for (int n = 0; n < 10 && !load_done; n++) tick();
    chk("ovf_done", 64'(load_done), 64'(1));
    tick();
    chk("ovf_idle", 64'({cpu_hold, load_done, overflow_err, word_count}), 64'({3'b001, 15'd4}));

    uart_complete = 1'b1;
    tick();
    uart_complete = 1'b0;
    chk("empty_prog", 64'({cpu_hold, load_done, overflow_err, word_count, checksum}), 64'({3'b010, 47'd0}));
    tick();
    chk("empty_after", 64'({cpu_hold, load_done}), 64'(0));

    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      uart_write_enable = 1'b1;
      uart_addr = 15'h20 + 15'(i);
      uart_data = 32'h55 + 32'(i);
      tick();
    end
    uart_write_enable = 1'b0;
    chk("rst_queued", 64'({imem_we, cpu_hold, word_count}), 64'({2'b11, 15'd2}));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid", 64'({imem_we, dmem_we, cpu_hold, word_count}), 64'(0));
    mem_ready = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      seen |= imem_we | dmem_we;
    end
    chk("rst_no_write", 64'(seen), 64'(0));

    uart_write_enable = 1'b1;
    uart_complete = 1'b1;
    uart_addr = 15'h0007;
    uart_data = 32'h0000CAFE;
    tick();
    uart_write_enable = 1'b0;
    uart_complete = 1'b0;
    chk("sim_write", 64'({imem_we, cpu_hold, load_done, mem_addr, mem_data}), 64'({3'b110, 14'h7, 32'h0000CAFE}));
    chk("sim_cnt", 64'({word_count, checksum}), 64'({15'd1, 32'h0000CAFE}));
    tick();
    chk("sim_done", 64'({imem_we, cpu_hold, load_done}), 64'(3'b011));
    tick();
    chk("sim_idle", 64'({cpu_hold, load_done}), 64'(0));

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
